// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: FSM states, next-PC select and
// architectural constants.
package mips_pkg;

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    RUN        = 2'd1,
    FAULT      = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } pc_sel_e;

  localparam logic [31:0] RESET_ADDR = 32'h0040_0000;
  localparam int unsigned ADDR_STEP  = 4;

endpackage

// File: rtl/pc_fetch_unit_next_pc_logic.sv
// Combinational next-PC selection: JR > J > taken branch > sequential, plus
// detection of a misaligned JR target.
module next_pc_logic
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STEP       = 4
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  branch,
  input  logic                  zero,
  input  logic                  jump,
  input  logic                  jump_reg,
  input  logic [DATA_WIDTH-1:0] branch_offset,
  input  logic [25:0]           jump_index,
  input  logic [DATA_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic [DATA_WIDTH-1:0] next_pc,
  output pc_sel_e               sel,
  output logic                  misaligned_tgt
);

  logic [DATA_WIDTH-1:0] br_off_sh;
  logic [DATA_WIDTH-1:0] br_tgt;
  logic [DATA_WIDTH-1:0] j_tgt;

  always_comb begin
    pc_plus4  = pc + DATA_WIDTH'(STEP);
    br_off_sh = branch_offset << 2;
    br_tgt    = pc_plus4 + br_off_sh;
    j_tgt     = {pc_plus4[DATA_WIDTH-1:28], jump_index, 2'b00};
  end

  always_comb begin
    sel     = SEL_SEQ;
    next_pc = pc_plus4;
    if (jump_reg) begin
      sel     = SEL_JR;
      next_pc = reg_addr;
    end else if (jump) begin
      sel     = SEL_J;
      next_pc = j_tgt;
    end else if (branch && zero) begin
      sel     = SEL_BR;
      next_pc = br_tgt;
    end
  end

  assign misaligned_tgt = jump_reg && (reg_addr[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, run/hold/fault sequencing and retired-fetch counter for the
// single-cycle MIPS core.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_ADDR = mips_pkg::RESET_ADDR,
  parameter int unsigned           ADDR_STEP  = mips_pkg::ADDR_STEP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_PC,
  input  logic                  Stall,
  input  logic                  Branch,
  input  logic                  Zero,
  input  logic                  Jump,
  input  logic                  JumpReg,
  input  logic [DATA_WIDTH-1:0] BranchOffset,
  input  logic [25:0]           JumpIndex,
  input  logic [DATA_WIDTH-1:0] RegAddr,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] PC_plus4,
  output logic                  Fetch_valid,
  output logic                  Misaligned,
  output logic [DATA_WIDTH-1:0] Instr_count
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  misaligned_q, misaligned_d;

  logic [DATA_WIDTH-1:0] next_pc;
  pc_sel_e               sel;
  logic                  misaligned_tgt;

  next_pc_logic #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP       (ADDR_STEP)
  ) u_next_pc (
    .pc             (pc_q),
    .branch         (Branch),
    .zero           (Zero),
    .jump           (Jump),
    .jump_reg       (JumpReg),
    .branch_offset  (BranchOffset),
    .jump_index     (JumpIndex),
    .reg_addr       (RegAddr),
    .pc_plus4       (PC_plus4),
    .next_pc        (next_pc),
    .sel            (sel),
    .misaligned_tgt (misaligned_tgt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= WAIT_START;
      pc_q         <= RESET_ADDR;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Dropping Start_PC wins over advancing, so a resumed run refetches the held PC.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    misaligned_d = misaligned_q;
    unique case (state_q)
      WAIT_START: begin
        if (Start_PC) state_d = RUN;
      end
      RUN: begin
        if (!Start_PC) begin
          state_d = WAIT_START;
        end else if (!Stall) begin
          if (sel == SEL_JR && misaligned_tgt) begin
            state_d      = FAULT;
            misaligned_d = 1'b1;
          end else begin
            pc_d    = next_pc;
            count_d = count_q + DATA_WIDTH'(1);
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = WAIT_START;
      end
    endcase
  end

  always_comb begin
    Fetch_valid = (state_q == RUN) && !Stall;
    PC          = pc_q;
    Instr_count = count_q;
    Misaligned  = misaligned_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with hand-computed PC values.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start_PC, Stall, Branch, Zero, Jump, JumpReg;
  logic [31:0] BranchOffset, RegAddr;
  logic [25:0] JumpIndex;
  logic [31:0] PC, PC_plus4, Instr_count;
  logic        Fetch_valid, Misaligned;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(
    .DATA_WIDTH (32),
    .RESET_ADDR (32'h0040_0000),
    .ADDR_STEP  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Start_PC     (Start_PC),
    .Stall        (Stall),
    .Branch       (Branch),
    .Zero         (Zero),
    .Jump         (Jump),
    .JumpReg      (JumpReg),
    .BranchOffset (BranchOffset),
    .JumpIndex    (JumpIndex),
    .RegAddr      (RegAddr),
    .PC           (PC),
    .PC_plus4     (PC_plus4),
    .Fetch_valid  (Fetch_valid),
    .Misaligned   (Misaligned),
    .Instr_count  (Instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] pc, input logic fv,
                              input logic [31:0] cnt, input logic mis);
    check({tag, ".pc"},  PC, pc);
    check({tag, ".fv"},  {31'd0, Fetch_valid}, {31'd0, fv});
    check({tag, ".cnt"}, Instr_count, cnt);
    check({tag, ".mis"}, {31'd0, Misaligned}, {31'd0, mis});
  endtask

  task automatic clear_ctl();
    Stall = 0; Branch = 0; Zero = 0; Jump = 0; JumpReg = 0;
    BranchOffset = '0; JumpIndex = '0; RegAddr = '0;
  endtask

  initial begin
    reset = 0; Start_PC = 0;
    clear_ctl();
    repeat (2) tick();
    expect_state("rst", 32'h0040_0000, 0, 0, 0);
    check("rst.pc4", PC_plus4, 32'h0040_0004);
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_state("wait", 32'h0040_0000, 0, 0, 0);
    end

    Start_PC = 1;
    tick(); expect_state("start", 32'h0040_0000, 1, 0, 0);
    tick(); expect_state("seq1", 32'h0040_0004, 1, 1, 0);
    tick(); expect_state("seq2", 32'h0040_0008, 1, 2, 0);
    tick(); tick();
    expect_state("seq4", 32'h0040_0010, 1, 4, 0);

    Branch = 1; Zero = 1; BranchOffset = 32'hFFFF_FFFE;
    #1 check("br.pc4", PC_plus4, 32'h0040_0014);
    tick(); expect_state("br_taken", 32'h0040_000C, 1, 5, 0);
    clear_ctl();
    tick(); check("seq5", PC, 32'h0040_0010);
    Branch = 1; Zero = 0; BranchOffset = 32'hFFFF_FFFE;
    tick(); expect_state("br_not", 32'h0040_0014, 1, 7, 0);

    clear_ctl(); JumpReg = 1; RegAddr = 32'h0040_0010;
    tick(); check("jr_back", PC, 32'h0040_0010);
    clear_ctl(); Jump = 1; JumpIndex = 26'h0100040;
    tick(); expect_state("jump", 32'h0040_0100, 1, 9, 0);
    clear_ctl(); JumpReg = 1; RegAddr = 32'h0040_0010;
    tick(); check("jr_back2", PC, 32'h0040_0010);
    Jump = 1; JumpIndex = 26'h0100040; JumpReg = 1; RegAddr = 32'h0040_0200;
    tick(); expect_state("jr_wins", 32'h0040_0200, 1, 11, 0);

    clear_ctl(); Stall = 1;
    #1 check("stall.fv", {31'd0, Fetch_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state("stall", 32'h0040_0200, 0, 11, 0);
    end
    Stall = 0;
    tick(); expect_state("resume", 32'h0040_0204, 1, 12, 0);

    Start_PC = 0;
    #1 check("drop.fv", {31'd0, Fetch_valid}, 32'd1);
    tick(); expect_state("drop1", 32'h0040_0204, 0, 12, 0);
    tick(); expect_state("drop2", 32'h0040_0204, 0, 12, 0);
    Start_PC = 1;
    tick(); expect_state("restart", 32'h0040_0204, 1, 12, 0);
    tick(); expect_state("restart_adv", 32'h0040_0208, 1, 13, 0);

    Stall = 1; JumpReg = 1; RegAddr = 32'h0040_0202;
    tick(); expect_state("mis_stall", 32'h0040_0208, 0, 13, 0);
    Stall = 0;
    tick(); expect_state("fault", 32'h0040_0208, 0, 13, 1);
    clear_ctl();
    tick(); expect_state("fault_hold", 32'h0040_0208, 0, 13, 1);
    reset = 0;
    tick(); expect_state("fault_rst", 32'h0040_0000, 0, 0, 0);
    reset = 1;

    tick(); expect_state("rerun", 32'h0040_0000, 1, 0, 0);
    JumpReg = 1; RegAddr = 32'hFFFF_FFFC;
    tick(); check("top.pc", PC, 32'hFFFF_FFFC);
    check("top.pc4", PC_plus4, 32'h0000_0000);
    clear_ctl();
    tick(); check("wrap.pc", PC, 32'h0000_0000);
    Branch = 1; Zero = 1; BranchOffset = 32'hFFFF_FFFE;
    tick(); expect_state("br_under", 32'hFFFF_FFFC, 1, 3, 0);

    clear_ctl(); reset = 0;
    tick(); expect_state("run_rst", 32'h0040_0000, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
